// File: rtl/maxnet_datapath.sv
// maxnet_datapath: arithmetic stage under the Maxnet controller.
// Holds N unsigned activations. Each controller pass runs one
// lateral-inhibition iteration:
//   prod[i] = (a[i]*EPS) >> EPS_FRAC
//   sum[i]  = a[i] - sum_{j!=i} prod[j]
//   a[i]    = ReLU(sum[i])
// It also flags convergence and captures the winning neuron on done.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   load_a       activation register write enable
//   load_sel     1 = load in_vec, 0 = load computed activations
//   done         capture winner index/value
//   in_vec       initial activations, neuron i at [i*DATA_W +: DATA_W]
//   is_finished  convergence flag (combinational from registered state)
//   winner_idx   captured winner index
//   winner_val   captured winner activation
//   result_valid winner_idx / winner_val are valid
module maxnet_datapath #(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int EPS      = 64,
  parameter int EPS_FRAC = 8,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_a,
  input  logic                load_sel,
  input  logic                done,
  input  logic [N*DATA_W-1:0] in_vec,
  output logic                is_finished,
  output logic [IDX_W-1:0]    winner_idx,
  output logic [DATA_W-1:0]   winner_val,
  output logic                result_valid
);

  localparam int SUM_W = DATA_W + IDX_W + 1;
  localparam int MUL_W = DATA_W + 32;
  localparam logic [31:0] EPS_C = 32'(EPS);

  logic [DATA_W-1:0]       a_r      [N];
  logic [DATA_W-1:0]       prod_r   [N];
  logic signed [SUM_W-1:0] sum_r    [N];
  logic                    changed_r;

  logic [DATA_W-1:0]       prod_next_s [N];
  logic signed [SUM_W-1:0] sum_next_s  [N];
  logic [DATA_W-1:0]       relu_s      [N];
  logic [DATA_W-1:0]       a_next_s    [N];
  logic                    diff_s;
  logic [IDX_W:0]          nz_cnt_s;
  logic [IDX_W-1:0]        best_idx_s;
  logic [DATA_W-1:0]       best_val_s;

  // Stage 1 product: scale by EPS and drop the fractional bits.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod_next_s[i] = DATA_W'((MUL_W'(a_r[i]) * MUL_W'(EPS_C)) >> EPS_FRAC);
    end
  end

  // Stage 2 inhibition: own activation minus every other neuron's product.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sum_next_s[i] = $signed({{(SUM_W-DATA_W){1'b0}}, a_r[i]});
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          sum_next_s[i] = sum_next_s[i] - $signed({{(SUM_W-DATA_W){1'b0}}, prod_r[j]});
        end else begin
          sum_next_s[i] = sum_next_s[i];
        end
      end
    end
  end

  // ReLU plus activation write-back mux. sum never exceeds a, so the
  // saturating branch is purely defensive.
  always_comb begin
    diff_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sum_r[i][SUM_W-1]) begin
        relu_s[i] = '0;
      end else if (|sum_r[i][SUM_W-2:DATA_W]) begin
        relu_s[i] = '1;
      end else begin
        relu_s[i] = sum_r[i][DATA_W-1:0];
      end
      if (load_sel) begin
        a_next_s[i] = in_vec[i*DATA_W +: DATA_W];
      end else begin
        a_next_s[i] = relu_s[i];
      end
      if (relu_s[i] != a_r[i]) begin
        diff_s = 1'b1;
      end else begin
        diff_s = diff_s;
      end
    end
  end

  // Nonzero count and argmax (strict > keeps the lowest index on ties).
  always_comb begin
    nz_cnt_s   = '0;
    best_idx_s = '0;
    best_val_s = a_r[0];
    for (int i = 0; i < N; i++) begin
      if (a_r[i] != '0) begin
        nz_cnt_s = nz_cnt_s + (IDX_W+1)'(1);
      end else begin
        nz_cnt_s = nz_cnt_s;
      end
      if (a_r[i] > best_val_s) begin
        best_val_s = a_r[i];
        best_idx_s = IDX_W'(i);
      end else begin
        best_val_s = best_val_s;
      end
    end
  end

  // A frozen activation set (changed=0) also counts as finished so that
  // truncation-locked ties cannot livelock the controller.
  assign is_finished = (nz_cnt_s <= (IDX_W+1)'(1)) || !changed_r;

  // Datapath registers: pipeline every cycle, activations only on load_a.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        a_r[i]    <= '0;
        prod_r[i] <= '0;
        sum_r[i]  <= '0;
      end
      changed_r <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        prod_r[i] <= prod_next_s[i];
        sum_r[i]  <= sum_next_s[i];
        if (load_a) begin
          a_r[i] <= a_next_s[i];
        end
      end
      if (load_a) begin
        changed_r <= load_sel ? 1'b1 : diff_s;
      end
    end
  end

  // Result capture: a fresh input load invalidates the result and wins over done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_idx   <= '0;
      winner_val   <= '0;
      result_valid <= 1'b0;
    end else if (load_a && load_sel) begin
      result_valid <= 1'b0;
    end else if (done) begin
      winner_idx   <= best_idx_s;
      winner_val   <= best_val_s;
      result_valid <= 1'b1;
    end
  end

endmodule
